mil_tx_encoder: RTL

Single-clock MIL-STD-1553 word transmitter. It accepts typed 16-bit words on a push handshake and produces a Manchester-II bipolar line pair (TXout/nTXout) with sync, data and odd parity. A one-word holding buffer allows contiguous back-to-back words. It is clocked from the system clock only, using an internal half-bit strobe instead of a separate io clock, and it is the transmit partner of the receiver on the same bus.

---
 rtl/mil_tx_encoder_pkg.sv | 15 +
 rtl/mil_halfbit_strobe.sv | 23 ++
 rtl/mil_tx_encoder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mil_tx_encoder_pkg.sv
// milStd1553: shared word types, frame geometry and parity helper for the 1553 transmitter.
package milStd1553;

    typedef enum logic [1:0] {WCOMMAND, WSTATUS, WDATA, WERROR} TxWordType;
    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} tx_state_t;

    localparam int SYNC_LEN      = 6;
    localparam int DATA_HALFBITS = 32;
    localparam int FRAME_LEN     = 40;

    function automatic logic oddParity(input logic [15:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/mil_halfbit_strobe.sv
// mil_halfbit_strobe: one-cycle pulse every CLK_PER_HALFBIT clocks, restarted by clear.
module mil_halfbit_strobe #(
    parameter int CLK_PER_HALFBIT = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic strobe
);

    localparam int W = CLK_PER_HALFBIT > 1 ? $clog2(CLK_PER_HALFBIT) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign strobe = cnt_q == W'(CLK_PER_HALFBIT - 1);

    always_comb cnt_d = (clear || strobe) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

endmodule

// File: rtl/mil_tx_encoder.sv
// mil_tx_encoder: MIL-STD-1553 Manchester-II word transmitter with one-word holding buffer.
// Optional fail-safe transmit limit enabled by defining MIL_TX_FAILSAFE_EN.
module mil_tx_encoder
    import milStd1553::*;
#(
    parameter int CLK_PER_HALFBIT  = 25,
    parameter int TIMEOUT_HALFBITS = 1600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_request,
    input  logic [1:0]  push_type,
    input  logic [15:0] push_data,
    output logic        push_done,
    input  logic        grant,
    output logic        TXout,
    output logic        nTXout,
    output logic        busy,
    output logic        timeout
);

    tx_state_t               state_q, state_d;
    logic [5:0]              hb_q, hb_d;
    logic [FRAME_LEN-1:0]    frame_q, frame_d;
    logic                    buf_full_q, buf_full_d;
    TxWordType               buf_type_q, buf_type_d;
    logic [15:0]             buf_data_q, buf_data_d;
    logic                    push_done_q, push_done_d;
    logic                    strobe, load, active, abort;

    // Whole frame precomputed as line levels, MSB goes out first.
    function automatic logic [FRAME_LEN-1:0] build_frame(input TxWordType t, input logic [15:0] d);
        logic [DATA_HALFBITS-1:0] m;
        logic p;
        for (int i = 0; i < 16; i++) m[2*i +: 2] = {d[i], ~d[i]};
        p = oddParity(d) ^ (t == WERROR);
        return {(t == WCOMMAND || t == WSTATUS) ? 6'b111000 : 6'b000111, m, p, ~p};
    endfunction

    mil_halfbit_strobe #(.CLK_PER_HALFBIT(CLK_PER_HALFBIT)) u_strobe (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == IDLE),
        .strobe (strobe)
    );

`ifdef MIL_TX_FAILSAFE_EN
    localparam int TW = $clog2(TIMEOUT_HALFBITS + 1);
    logic [TW-1:0] to_q, to_d;
    logic          timeout_q, timeout_d;

    assign abort     = state_q != IDLE && strobe && to_q == TW'(TIMEOUT_HALFBITS - 1);
    assign to_d      = (state_q == IDLE || abort) ? '0 : to_q + TW'(strobe);
    assign timeout_d = timeout_q | abort;
    assign timeout   = timeout_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            to_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_q      <= to_d;
            timeout_q <= timeout_d;
        end
`else
    assign abort   = 1'b0;
    assign timeout = TIMEOUT_HALFBITS < 0;
`endif

    always_comb begin
        state_d     = state_q;
        hb_d        = hb_q;
        frame_d     = frame_q;
        buf_full_d  = buf_full_q;
        buf_type_d  = buf_type_q;
        buf_data_d  = buf_data_q;
        push_done_d = push_request & ~buf_full_q;
        load        = state_q == IDLE && buf_full_q && grant;
        if (push_request && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_type_d = TxWordType'(push_type);
            buf_data_d = push_data;
        end
        if (state_q != IDLE && strobe) begin
            frame_d = {frame_q[FRAME_LEN-2:0], 1'b0};
            hb_d    = hb_q + 6'd1;
            state_d = hb_q == 6'(SYNC_LEN - 1)                 ? DATA   :
                      hb_q == 6'(SYNC_LEN + DATA_HALFBITS - 1) ? PARITY :
                      hb_q == 6'(FRAME_LEN - 1)                ? IDLE   : state_q;
            // Contiguous follow-on word: reload at the last parity strobe, no gap.
            if (hb_q == 6'(FRAME_LEN - 1) && buf_full_q && grant) load = 1'b1;
        end
        if (load) begin
            state_d    = SYNC;
            hb_d       = '0;
            frame_d    = build_frame(buf_type_q, buf_data_q);
            buf_full_d = 1'b0;
        end
        if (abort) begin
            state_d     = IDLE;
            buf_full_d  = 1'b0;
            push_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= IDLE;
            hb_q        <= '0;
            frame_q     <= '0;
            buf_full_q  <= 1'b0;
            buf_type_q  <= WCOMMAND;
            buf_data_q  <= '0;
            push_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hb_q        <= hb_d;
            frame_q     <= frame_d;
            buf_full_q  <= buf_full_d;
            buf_type_q  <= buf_type_d;
            buf_data_q  <= buf_data_d;
            push_done_q <= push_done_d;
        end

    assign active    = state_q != IDLE;
    assign TXout     = active & frame_q[FRAME_LEN-1];
    assign nTXout    = active & ~frame_q[FRAME_LEN-1];
    assign busy      = active | buf_full_q;
    assign push_done = push_done_q;

endmodule
